fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end; successor to the single-cycle datapath's PC register and pc+4/pc+8 logic.
- Owns the fetch PC and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a DEPTH-entry prefetch queue. Each entry is tagged with its PC and a precomputed PC+8, the R15 read value.
- Supports redirect (branch/jump) with queue flush and discard of the in-flight response.

---
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a DEPTH-entry prefetch queue.
// Optional FETCH_ALIGN_FAULT_EN: sticky fault flag on misaligned redirect.
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_plus8,
  output logic              fault
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DISC = 2'd3;

  localparam logic [ADDR_W-1:0] WMASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] EIGHT = ADDR_W'(8);

  logic [1:0]        state, state_d;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] tgt_pc;

  logic [DATA_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0] q_pc [DEPTH];
  logic [ADDR_W-1:0] q_pc8 [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_after;
  logic          deq, enq;

  assign imem_req = (state == S_PEND);
  assign imem_addr = fetch_pc;

  assign out_valid = (count != '0);
  assign out_instr = q_instr[rd_ptr];
  assign out_pc = q_pc[rd_ptr];
  assign out_pc_plus8 = q_pc8[rd_ptr];

  assign deq = out_valid && out_ready;
  assign enq = (state == S_RESP) && imem_rvalid && !redirect;

  // fetch_pc advanced at gnt and is frozen until the response lands
  assign resp_pc = fetch_pc - FOUR;
  assign tgt_pc = redirect_addr & WMASK;
  assign count_after = count + CW'(enq) - CW'(deq);

  // next-state logic of the request/response handshake
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (redirect || count < FULL)
          state_d = S_PEND;
      end
      S_PEND: begin
        if (redirect)
          state_d = imem_gnt ? S_DISC : S_IDLE;
        else if (imem_gnt)
          state_d = S_RESP;
      end
      S_RESP: begin
        if (redirect)
          state_d = imem_rvalid ? S_IDLE : S_DISC;
        else if (imem_rvalid)
          state_d = (count_after < FULL) ? S_PEND : S_IDLE;
      end
      S_DISC: begin
        if (imem_rvalid)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state register and fetch PC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_d;
      if (redirect)
        fetch_pc <= tgt_pc;
      else if (state == S_PEND && imem_gnt)
        fetch_pc <= fetch_pc + FOUR;
    end
  end

  // prefetch queue pointers and occupancy; redirect flush wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (enq)
        wr_ptr <= wr_ptr + PW'(1);
      if (deq)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count_after;
    end
  end

  // queue storage, cleared on reset so outputs read zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i] <= '0;
        q_pc8[i] <= '0;
      end
    end else if (enq) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr] <= resp_pc;
      q_pc8[wr_ptr] <= resp_pc + EIGHT;
    end
  end

`ifdef FETCH_ALIGN_FAULT_EN
  logic fault_q;

  // sticky flag for a redirect target that is not word aligned
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fault_q <= 1'b0;
    else if (redirect && redirect_addr[1:0] != 2'b00)
      fault_q <= 1'b1;
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit.
// Driver models memory and the expected instruction stream; monitor checks.
module tb_fetch_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h100;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus8;
  logic        fault;

  fetch_unit #(
    .ADDR_W(32),
    .DATA_W(32),
    .DEPTH(DEPTH),
    .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_addr(redirect_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_pc_plus8(out_pc_plus8),
    .fault(fault)
  );

  always #5 clk = ~clk;

  ent_t sb[$];
  int checks = 0;
  int errors = 0;

  int gnt_pct = 100;
  int min_lat = 0;
  int max_lat = 0;
  int rdy_pct = 100;
  int redir_pm = 0;
  int mode = 0;
  logic [31:0] mode_tgt = '0;

  logic [31:0] exp_fetch = RPC;
  bit outstanding = 0;
  bit tainted = 0;
  int lat_cnt = 0;
  logic [31:0] cur_addr = '0;
  bit pend_v = 0;
  ent_t pend_e;
  bit exp_fault = 0;
  ent_t mon_e;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] rand_tgt();
    case ($urandom_range(3))
      0: return 32'h200;
      1: return 32'h302;
      2: return 32'hFFFF_FFE0 | 32'($urandom_range(31));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals();
    chk(!out_valid, "rst_out_valid", 32'(out_valid), 0);
    chk(!imem_req, "rst_imem_req", 32'(imem_req), 0);
    chk(out_instr == 0, "rst_out_instr", out_instr, 0);
    chk(out_pc == 0, "rst_out_pc", out_pc, 0);
    chk(out_pc_plus8 == 0, "rst_out_pc8", out_pc_plus8, 0);
    chk(!fault, "rst_fault", 32'(fault), 0);
    chk(imem_addr == RPC, "rst_imem_addr", imem_addr, RPC);
  endtask

  // one bus cycle: memory model, consumer, redirect source, reference model
  task automatic cycle();
    bit fire;
    @(posedge clk);
    #1;
    if (pend_v) begin
      sb.push_back(pend_e);
      pend_v = 0;
    end
    imem_gnt = 0;
    imem_rvalid = 0;
    imem_rdata = '0;
    redirect = 0;
    redirect_addr = $urandom;
    out_ready = ($urandom_range(99) < rdy_pct);
    if (outstanding) begin
      chk(!imem_req, "req_while_busy", 32'(imem_req), 0);
      if (lat_cnt == 0) begin
        imem_rvalid = 1;
        imem_rdata = memf(cur_addr);
      end else begin
        lat_cnt--;
      end
    end else if (imem_req) begin
      chk(imem_addr == exp_fetch, "fetch_addr", imem_addr, exp_fetch);
      imem_gnt = ($urandom_range(99) < gnt_pct);
    end
    if (sb.size() >= DEPTH)
      chk(!imem_req, "req_when_full", 32'(imem_req), 0);
    fire = 0;
    case (mode)
      1: fire = outstanding && !imem_rvalid;
      2: fire = imem_rvalid && out_valid;
      3: fire = 1;
      default: fire = 0;
    endcase
    if (fire) begin
      redirect = 1;
      redirect_addr = mode_tgt;
      if (mode == 2)
        out_ready = 1;
      mode = 0;
    end else if (mode == 0 && $urandom_range(999) < redir_pm) begin
      redirect = 1;
      redirect_addr = rand_tgt();
    end
    if (redirect) begin
      if (outstanding)
        tainted = 1;
      exp_fetch = redirect_addr & ~32'h3;
    end else if (imem_gnt) begin
      exp_fetch = exp_fetch + 4;
    end
    if (imem_gnt) begin
      outstanding = 1;
      tainted = redirect;
      cur_addr = imem_addr;
      lat_cnt = $urandom_range(max_lat, min_lat);
    end else if (imem_rvalid) begin
      outstanding = 0;
      if (!tainted && !redirect) begin
        pend_v = 1;
        pend_e = '{memf(cur_addr), cur_addr, cur_addr + 32'd8};
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_until_fired(input int n, input string name);
    for (int i = 0; i < n && mode != 0; i++)
      cycle();
    chk(mode == 0, name, 32'(mode), 0);
    mode = 0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset = 1;
    redirect = 0;
    imem_gnt = 0;
    imem_rvalid = 0;
    out_ready = 0;
    outstanding = 0;
    tainted = 0;
    pend_v = 0;
    exp_fetch = RPC;
    sb.delete();
    #1;
    chk_reset_vals();
    repeat (n) @(posedge clk);
    #1;
    reset = 0;
  endtask

  // monitor: compares every dequeued entry against the scoreboard head
  always @(negedge clk) begin
    if (reset) begin
      exp_fault = 0;
    end else begin
      chk(out_valid == (sb.size() != 0), "out_valid",
          32'(out_valid), 32'(sb.size() != 0));
      if (out_valid && out_ready && sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk(out_pc == mon_e.pc, "out_pc", out_pc, mon_e.pc);
        chk(out_instr == mon_e.instr, "out_instr", out_instr, mon_e.instr);
        chk(out_pc_plus8 == mon_e.pc8, "out_pc8", out_pc_plus8, mon_e.pc8);
      end
      chk(fault == exp_fault, "fault", 32'(fault), 32'(exp_fault));
      if (redirect) begin
        sb.delete();
`ifdef FETCH_ALIGN_FAULT_EN
        if (redirect_addr[1:0] != 2'b00)
          exp_fault = 1;
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    reset = 0;

    // sequential fetch, 1-cycle memory, consumer always ready
    gnt_pct = 100; min_lat = 0; max_lat = 0; rdy_pct = 100; redir_pm = 0;
    run(20);

    // consumer stalled: queue fills and fetching stops
    rdy_pct = 0;
    run(30);
    chk(sb.size() == DEPTH, "full_entries", 32'(sb.size()), DEPTH);
    chk(!imem_req, "full_no_req", 32'(imem_req), 0);
    rdy_pct = 100;
    run(20);

    // redirect while a slow response is outstanding
    do_reset(2);
    run(3);
    min_lat = 3; max_lat = 3;
    mode = 1; mode_tgt = 32'h200;
    run_until_fired(20, "fire_resp_redirect");
    run(20);
    min_lat = 0; max_lat = 0;

    // redirect together with rvalid and a dequeue
    rdy_pct = 40;
    mode = 2; mode_tgt = 32'h400;
    run_until_fired(300, "fire_rvalid_redirect");
    run(20);

    // misaligned redirect target
    rdy_pct = 100;
    mode = 3; mode_tgt = 32'h302;
    cycle();
    cycle();
    chk(imem_addr == 32'h300, "align_addr", imem_addr, 32'h300);
    run(20);

    // reset while a response is outstanding
    min_lat = 2; max_lat = 4;
    for (int i = 0; i < 50 && !outstanding; i++)
      cycle();
    chk(outstanding, "found_resp", 32'(outstanding), 1);
    do_reset(2);
    cycle();
    chk(imem_addr == RPC, "restart_pc", imem_addr, RPC);
    run(20);

    // randomized traffic
    gnt_pct = 70; min_lat = 0; max_lat = 4; rdy_pct = 60; redir_pm = 20;
    run(3000);
    gnt_pct = 90; max_lat = 2; rdy_pct = 85; redir_pm = 100;
    run(1500);
    redir_pm = 0; rdy_pct = 100;
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
